node_fetch: RTL and testbench

- Read-side front end for the dual-port node SRAM: accepts node-fetch requests over a valid/ready handshake and drives the SRAM read address.
- Absorbs the SRAM's fixed 1-cycle read latency and returns node words with their request tags through a backpressurable response buffer.
- Snoops the SRAM write port so a read issued in the same cycle as a write to the same address returns the new data.
- Sits between the traversal/apply logic upstream and the SRAM read port (addr_b/q_b).

---
 rtl/bdd_pkg.sv | 17 +
 rtl/node_fetch_fifo.sv | 57 +++++
 rtl/node_fetch.sv | 94 +++++++++
 tb/tb_node_fetch.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bdd_pkg.sv
// Shared types for the node SRAM read path: node word, fetch tag and the
// {data, tag} response record that travels through the response buffer.
package bdd_pkg;

  localparam int NODE_ADDR_WIDTH = 8;
  localparam int NODE_DATA_WIDTH = 34;
  localparam int FETCH_TAG_WIDTH = 4;

  typedef logic [NODE_DATA_WIDTH-1:0] node_word_t;
  typedef logic [FETCH_TAG_WIDTH-1:0] fetch_tag_t;

  typedef struct packed {
    node_word_t data;
    fetch_tag_t tag;
  } fetch_resp_t;

endpackage

// File: rtl/node_fetch_fifo.sv
// Small in-order response FIFO. The head entry is presented combinationally
// so the consumer sees a stable word for as long as it is not popped.
module node_fetch_fifo
  import bdd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  fetch_resp_t      push_data,
  input  logic             pop,
  output fetch_resp_t      head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_resp_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    if (int'(p) == DEPTH - 1) return '0;
    return p + 1'b1;
  endfunction

  // Popping an empty FIFO is ignored so the count can never underflow.
  assign pop_ok = pop && (count_reg != '0);

  // Storage: entries carry no reset, only the occupancy state does.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  // Occupancy and pointer update; push+pop together leaves count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push)   wr_ptr_reg <= next_ptr(wr_ptr_reg);
      if (pop_ok) rd_ptr_reg <= next_ptr(rd_ptr_reg);
      if (push && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (!push && pop_ok) count_reg <= count_reg - 1'b1;
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/node_fetch.sv
// Read-side front end for the node SRAM. Issues reads straight onto addr_b,
// captures q_b one cycle later (or a same-edge snooped write), and queues the
// result with its tag in a credit-protected response buffer.
module node_fetch
  import bdd_pkg::*;
#(
  parameter int ADDR_WIDTH = NODE_ADDR_WIDTH,
  parameter int DATA_WIDTH = NODE_DATA_WIDTH,
  parameter int TAG_WIDTH  = FETCH_TAG_WIDTH,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  snoop_we,
  input  logic [ADDR_WIDTH-1:0] snoop_addr,
  input  logic [DATA_WIDTH-1:0] snoop_data,
  output logic [ADDR_WIDTH-1:0] sram_addr_b,
  input  logic [DATA_WIDTH-1:0] sram_q_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  logic                  inflight_reg;
  logic [TAG_WIDTH-1:0]  tag_reg;
  logic                  fwd_hit_reg;
  logic [DATA_WIDTH-1:0] fwd_data_reg;

  logic                  issue;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  fetch_resp_t           push_data;
  fetch_resp_t           head;

  // The SRAM samples the request address at the issue edge itself.
  assign sram_addr_b = req_addr;

  // Credit check counts the in-flight read as an occupied slot, so a capture
  // can never find the buffer full. Uses registered state only.
  assign req_ready = rst_n && ((int'(count) + int'(inflight_reg)) < BUF_DEPTH);
  assign issue     = req_valid && req_ready;

  // Issue-side capture: remember the tag and any write landing at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_reg <= 1'b0;
      tag_reg      <= '0;
      fwd_hit_reg  <= 1'b0;
      fwd_data_reg <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        tag_reg      <= req_tag;
        fwd_hit_reg  <= snoop_we && (snoop_addr == req_addr);
        fwd_data_reg <= snoop_data;
      end
    end
  end

  // Capture the read word; a write at the issue edge supersedes the SRAM's old data.
  always_comb begin
    push_data      = '0;
    push_data.data = fwd_hit_reg ? fwd_data_reg : sram_q_b;
    push_data.tag  = tag_reg;
  end

  assign pop = resp_valid && resp_ready;

  node_fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_reg),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  assign resp_valid = (count != '0);
  assign resp_data  = head.data;
  assign resp_tag   = head.tag;
  assign busy       = inflight_reg || (count != '0);

endmodule

// File: tb/tb_node_fetch.sv
// Scoreboard bench for node_fetch with a behavioural dual-port SRAM.
module tb_node_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [3:0]  req_tag;
  logic        snoop_we;
  logic [7:0]  snoop_addr;
  logic [33:0] snoop_data;
  logic [7:0]  sram_addr_b;
  logic [33:0] sram_q_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [33:0] resp_data;
  logic [3:0]  resp_tag;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [37:0] exp_q[$];        // {data, tag} in expected order
  logic [33:0] model_mem [256]; // reference memory contents
  logic [33:0] sram [256];      // environment SRAM

  always #5 clk = ~clk;

  node_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_tag     (req_tag),
    .snoop_we    (snoop_we),
    .snoop_addr  (snoop_addr),
    .snoop_data  (snoop_data),
    .sram_addr_b (sram_addr_b),
    .sram_q_b    (sram_q_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_tag    (resp_tag),
    .busy        (busy)
  );

  // Dual-port SRAM: port A writes, port B reads old data with 1-cycle latency.
  always @(posedge clk) begin
    if (snoop_we) sram[snoop_addr] <= snoop_data;
    sram_q_b <= sram[sram_addr_b];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, decide acceptance before the next posedge.
  task automatic cycle(input logic v, input logic [7:0] a, input logic [3:0] t,
                       input logic we, input logic [7:0] wa, input logic [33:0] wd,
                       input logic rr, output logic acc);
    @(negedge clk);
    req_valid = v; req_addr = a; req_tag = t;
    snoop_we = we; snoop_addr = wa; snoop_data = wd;
    resp_ready = rr;
    #1;
    acc = v && req_ready;
    if (acc) begin
      // A write at the issue edge is ordered before the read.
      exp_q.push_back({(we && wa == a) ? wd : model_mem[a], t});
      $display("req  addr=%0d tag=%0d", a, t);
    end
    if (we) model_mem[wa] = wd;
  endtask

  task automatic idle(input logic rr);
    logic acc;
    cycle(1'b0, 8'd0, 4'd0, 1'b0, 8'd0, 34'd0, rr, acc);
  endtask

  task automatic wr(input logic [7:0] wa, input logic [33:0] wd);
    logic acc;
    cycle(1'b0, 8'd0, 4'd0, 1'b1, wa, wd, 1'b1, acc);
  endtask

  // Monitor: pops the scoreboard on each accepted response and checks stalls.
  initial begin : monitor
    logic        held_v;
    logic [37:0] held;
    logic [37:0] e;
    held_v = 1'b0;
    held   = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        held_v = 1'b0;
      end else begin
        chk("outstanding_le_3", 64'(exp_q.size() <= 3), 64'd1);
        if (held_v) chk("stall_stable", {25'd0, resp_valid, resp_data, resp_tag}, {25'd0, 1'b1, held});
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            $display("resp data=%0h tag=%0d", resp_data, resp_tag);
            chk("resp_data", 64'(resp_data), 64'(e[37:4]));
            chk("resp_tag", 64'(resp_tag), 64'(e[3:0]));
          end
          held_v = 1'b0;
        end else if (resp_valid) begin
          held_v = 1'b1;
          held   = {resp_data, resp_tag};
        end else begin
          held_v = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic acc;
    int   nacc;
    int   cyc;
    int   tagc;
    rst_n = 1'b0;
    req_valid = 0; req_addr = 0; req_tag = 0;
    snoop_we = 0; snoop_addr = 0; snoop_data = 0; resp_ready = 0;
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = '0;
      sram[i] = '0;
    end

    // Reset state
    #2;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    // Preload the working set
    for (int i = 0; i < 16; i++) wr(8'(i), 34'({$urandom, 2'b01}));
    wr(8'd5, 34'h2_0000_0005);

    // Single request, latency of one cycle
    cycle(1'b1, 8'd5, 4'd3, 1'b0, 8'd0, 34'd0, 1'b1, acc);
    chk("single_accept", 64'(acc), 64'd1);
    idle(1'b1);
    chk("lat_before_capture", 64'(resp_valid), 64'd0);
    idle(1'b1);
    chk("lat_after_capture", 64'(resp_valid), 64'd1);
    idle(1'b1);

    // Streaming: 8 back-to-back requests
    for (int i = 0; i < 8; i++) wr(8'(i), 34'(i * 17));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'(i), 4'(i), 1'b0, 8'd0, 34'd0, 1'b1, acc);
      chk("stream_accept", 64'(acc), 64'd1);
      if (i >= 2) chk("stream_resp_valid", 64'(resp_valid), 64'd1);
    end
    idle(1'b1);
    chk("stream_tail_valid0", 64'(resp_valid), 64'd1);
    idle(1'b1);
    chk("stream_tail_valid1", 64'(resp_valid), 64'd1);
    idle(1'b1);
    idle(1'b1);

    // Backpressure fills exactly three credits
    nacc = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 8'(i), 4'(8 + i), 1'b0, 8'd0, 34'd0, 1'b0, acc);
      if (acc) nacc++;
    end
    chk("bp_accepted", 64'(nacc), 64'd3);
    idle(1'b0);
    chk("bp_req_ready", 64'(req_ready), 64'd0);
    repeat (5) idle(1'b1);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);
    chk("bp_ready_back", 64'(req_ready), 64'd1);
    chk("bp_busy", 64'(busy), 64'd0);

    // Forwarding: same-edge write forwarded, next-edge write not
    wr(8'd9, 34'h1_1111_1111);
    cycle(1'b1, 8'd9, 4'd1, 1'b1, 8'd9, 34'h3_DEAD_BEEF, 1'b1, acc);
    chk("fwd_accept", 64'(acc), 64'd1);
    cycle(1'b1, 8'd9, 4'd2, 1'b0, 8'd0, 34'd0, 1'b1, acc);
    cycle(1'b0, 8'd0, 4'd0, 1'b1, 8'd9, 34'h0_1234_5678, 1'b1, acc);
    repeat (3) idle(1'b1);

    // Random traffic with random backpressure and write snooping
    nacc = 0; cyc = 0; tagc = 0;
    while (nacc < 200 && cyc < 5000) begin
      logic [7:0] a, wa;
      logic v, we, rr;
      a  = 8'($urandom_range(0, 15));
      wa = $urandom_range(0, 3) == 0 ? a : 8'($urandom_range(0, 15));
      v  = $urandom_range(0, 3) != 0;
      we = $urandom_range(0, 2) == 0;
      rr = $urandom_range(0, 2) != 0;
      cycle(v, a, 4'(tagc), we, wa, 34'({$urandom, 2'b10}), rr, acc);
      if (acc) begin
        nacc++;
        tagc++;
      end
      cyc++;
    end
    chk("rand_all_issued", 64'(nacc), 64'd200);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 50) begin
      idle(1'b1);
      cyc++;
    end
    chk("rand_drained", 64'(exp_q.size()), 64'd0);

    // Reset with one in flight and two buffered
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i), 4'(i), 1'b0, 8'd0, 34'd0, 1'b0, acc);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("pre_rst_busy", 64'(busy), 64'd1);
    chk("pre_rst_valid", 64'(resp_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", 64'(req_ready), 64'd1);
    repeat (6) idle(1'b1);
    chk("rel_no_stale", 64'(resp_valid), 64'd0);
    chk("rel_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
